// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS definitions for the PC sequencer: opcode/funct constants,
// the sequencer state encoding, the control-flow class of an instruction
// and a helper that says whether a class/taken pair redirects the PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_REGIMM = 6'd1;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_JAL    = 6'd3;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BNE    = 6'd5;
    localparam logic [5:0] OP_BLEZ   = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;

    localparam logic [5:0] FN_JR     = 6'd8;
    localparam logic [5:0] FN_JALR   = 6'd9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        WAIT,
        UPDATE
    } seq_state_t;

    typedef enum logic [2:0] {
        BR,
        J,
        JAL,
        JR,
        JALR,
        SEQ
    } ctl_class_t;

    // Conditional branches redirect only when taken; every jump form always
    // redirects; sequential instructions never do.
    function automatic logic is_redirect(input ctl_class_t cls, input logic taken);
        logic r;
        case (cls)
            BR:                  r = taken;
            J, JAL, JR, JALR:    r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_branch_sequencer_if.sv
// pc_branch_sequencer_if
// Bundles the instruction-memory fetch channel and the branch-condition
// evaluator channel of the PC sequencer.
//   imem_req/imem_addr : fetch request and address (sequencer -> memory)
//   imem_ack/imem_rdata: fetch response (memory -> sequencer)
//   ir                 : latched instruction (sequencer -> evaluator/datapath)
//   bflag/cmp_valid    : branch decision (evaluator -> sequencer)
//
// Handshake: a transfer happens on a rising edge where the producer's
// qualifier is high while the consumer is waiting for it. imem_ack is
// honoured only while imem_req is high (ack may arrive in the first request
// cycle); cmp_valid is honoured only while the sequencer waits on a
// conditional branch, and bflag is meaningful only when cmp_valid is high.
interface pc_branch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        bflag;
    logic        cmp_valid;

    modport master (
        output imem_req, imem_addr, ir,
        input  imem_ack, imem_rdata, bflag, cmp_valid
    );

    modport slave (
        input  imem_req, imem_addr, ir,
        output imem_ack, imem_rdata, bflag, cmp_valid
    );
endinterface

// File: rtl/pc_branch_sequencer_target_calc.sv
// pc_target_calc
// Combinational control-flow decode and target generation.
//   ir       in  32  latched instruction
//   pc4      in  32  address of the following instruction
//   rs_value in  32  register rs (JR/JALR target)
//   cls      out     control-flow class
//   target   out 32  redirect target for the class (pc4 for SEQ)
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [31:0] ir,
    input  logic [31:0] pc4,
    input  logic [31:0] rs_value,
    output ctl_class_t  cls,
    output logic [31:0] target
);

    logic [5:0]  opcode;
    logic [4:0]  rt;
    logic [5:0]  funct;
    logic [31:0] br_off;
    logic [31:0] jmp_target;
    logic [31:0] reg_target;

    assign opcode     = ir[31:26];
    assign rt         = ir[20:16];
    assign funct      = ir[5:0];
    assign br_off     = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jmp_target = {pc4[31:28], ir[25:0], 2'b00};
    // Register targets are forced word aligned.
    assign reg_target = rs_value & 32'hFFFF_FFFC;

    always_comb begin
        cls    = SEQ;
        target = pc4;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                cls    = BR;
                target = pc4 + br_off;
            end
            OP_REGIMM: begin
                // Only BLTZ (rt=0) and BGEZ (rt=1) are branches here.
                if (rt[4:1] == 4'd0) begin
                    cls    = BR;
                    target = pc4 + br_off;
                end
            end
            OP_J: begin
                cls    = J;
                target = jmp_target;
            end
            OP_JAL: begin
                cls    = JAL;
                target = jmp_target;
            end
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    cls    = JR;
                    target = reg_target;
                end else if (funct == FN_JALR) begin
                    cls    = JALR;
                    target = reg_target;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pc_branch_sequencer.sv
// pc_branch_sequencer
// Multi-cycle PC sequencer: fetch, decode control-flow class, wait for the
// branch decision or datapath completion, then commit the next PC.
//   clk, rst_n     clock; synchronous active-low reset
//   run            keep sequencing (0 = stop at next instruction boundary)
//   bus            fetch channel and evaluator channel (master side)
//   exec_done      datapath finished a non-control instruction
//   rs_value       register rs for JR/JALR
//   pc             current PC
//   link_valid     pulse in UPDATE for JAL/JALR; write link_pc
//   link_pc        pc+4 of the retiring instruction
//   branch_taken   pulse in UPDATE when the PC is redirected
//   retire         pulse in UPDATE, one per committed instruction
//   instr_count    committed-instruction counter
//   state_dbg      current FSM state
module pc_branch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    pc_branch_sequencer_if.master        bus,
    input  logic                         exec_done,
    input  logic [31:0]                  rs_value,
    output logic [31:0]                  pc,
    output logic                         link_valid,
    output logic [31:0]                  link_pc,
    output logic                         branch_taken,
    output logic                         retire,
    output logic [31:0]                  instr_count,
    output seq_state_t                   state_dbg
);

    seq_state_t  state;
    seq_state_t  state_next;

    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    logic [31:0] ir_q;
    ctl_class_t  cls_q;
    logic [31:0] target_q;
    logic        taken_q;
    logic [31:0] count_q;

    ctl_class_t  calc_cls;
    logic [31:0] calc_target;
    logic        redirect;

    pc_target_calc u_target_calc (
        .ir       (ir_q),
        .pc4      (pc4_q),
        .rs_value (rs_value),
        .cls      (calc_cls),
        .target   (calc_target)
    );

    // Decided entirely from registered class/taken, so no input reaches
    // an output combinationally.
    assign redirect = is_redirect(cls_q, taken_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            pc4_q    <= 32'd0;
            ir_q     <= 32'd0;
            cls_q    <= SEQ;
            target_q <= 32'd0;
            taken_q  <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            state <= state_next;
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir_q  <= bus.imem_rdata;
                        pc4_q <= pc_q + 32'd4;
                    end
                end
                DECODE: begin
                    cls_q    <= calc_cls;
                    target_q <= calc_target;
                    taken_q  <= 1'b0;
                end
                WAIT: begin
                    if (cls_q == BR && bus.cmp_valid) begin
                        taken_q <= bus.bflag;
                    end
                end
                UPDATE: begin
                    pc_q    <= redirect ? target_q : pc4_q;
                    count_q <= count_q + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                if (bus.imem_ack) state_next = DECODE;
            end
            DECODE: begin
                if (calc_cls == BR || calc_cls == SEQ) state_next = WAIT;
                else                                    state_next = UPDATE;
            end
            WAIT: begin
                // Only the completion input matching the class counts.
                if (cls_q == BR) begin
                    if (bus.cmp_valid) state_next = UPDATE;
                end else begin
                    if (exec_done) state_next = UPDATE;
                end
            end
            UPDATE: begin
                state_next = run ? FETCH : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.imem_req  = (state == FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.ir        = ir_q;

    assign pc            = pc_q;
    assign link_pc       = pc4_q;
    assign retire        = (state == UPDATE);
    assign branch_taken  = (state == UPDATE) && redirect;
    assign link_valid    = (state == UPDATE) && (cls_q == JAL || cls_q == JALR);
    assign instr_count   = count_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    localparam int RC_BR   = 0;
    localparam int RC_J    = 1;
    localparam int RC_JAL  = 2;
    localparam int RC_JR   = 3;
    localparam int RC_JALR = 4;
    localparam int RC_SEQ  = 5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic run;
    logic exec_done;
    logic [31:0] rs_value;
    logic [31:0] pc;
    logic link_valid;
    logic [31:0] link_pc;
    logic branch_taken;
    logic retire;
    logic [31:0] instr_count;
    mips_pkg::seq_state_t state_dbg;

    pc_branch_sequencer_if bus ();

    pc_branch_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .bus          (bus),
        .exec_done    (exec_done),
        .rs_value     (rs_value),
        .pc           (pc),
        .link_valid   (link_valid),
        .link_pc      (link_pc),
        .branch_taken (branch_taken),
        .retire       (retire),
        .instr_count  (instr_count),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_class(input logic [31:0] w);
        int op;
        int rt;
        int fn;
        op = int'(w[31:26]);
        rt = int'(w[20:16]);
        fn = int'(w[5:0]);
        if (op >= 4 && op <= 7) return RC_BR;
        if (op == 1 && rt <= 1) return RC_BR;
        if (op == 2) return RC_J;
        if (op == 3) return RC_JAL;
        if (op == 0 && fn == 8) return RC_JR;
        if (op == 0 && fn == 9) return RC_JALR;
        return RC_SEQ;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] w, input logic [31:0] cur,
                                               input logic [31:0] rs);
        logic [31:0] nxt;
        logic signed [31:0] off;
        int cls;
        nxt = cur + 32'd4;
        cls = ref_class(w);
        if (cls == RC_BR) begin
            off = 32'(signed'(w[15:0]));
            return nxt + 32'(off * 32'sd4);
        end
        if (cls == RC_J || cls == RC_JAL)
            return (nxt & 32'hF000_0000) + 32'(w[25:0]) * 32'd4;
        if (cls == RC_JR || cls == RC_JALR)
            return rs - (rs % 32'd4);
        return nxt;
    endfunction

    // ---------------- driver ----------------
    // Entered and left on a falling edge.
    task automatic exec_instr(input logic [31:0] w, input logic [31:0] rs, input bit bf,
                              input int ack_dly, input int wt_dly, input bit distract,
                              input bit drop_run, input bit rst_wait);
        int cls;
        bit redir;
        bit lnk;
        int guard;
        logic [31:0] exp_pc;

        cls   = ref_class(w);
        redir = (cls == RC_BR) ? bf : (cls != RC_SEQ);
        lnk   = (cls == RC_JAL) || (cls == RC_JALR);
        exp_pc = redir ? ref_target(w, model_pc, rs) : model_pc + 32'd4;
        exp_q.push_back(exp_pc);

        guard = 0;
        while (bus.imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("fetch_req", {31'd0, bus.imem_req}, 32'd1);
        if (bus.imem_req !== 1'b1) begin
            void'(exp_q.pop_front());
            return;
        end
        check("imem_addr", bus.imem_addr, model_pc);
        rs_value = rs;

        for (int k = 0; k <= ack_dly; k++) begin
            bus.imem_ack   = (k == ack_dly);
            bus.imem_rdata = (k == ack_dly) ? w : $urandom;
            @(negedge clk);
        end
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;

        // DECODE
        check("ir_decode", bus.ir, w);
        check("retire_decode", {31'd0, retire}, 32'd0);
        check("imem_req_decode", {31'd0, bus.imem_req}, 32'd0);
        @(negedge clk);

        if (cls == RC_BR || cls == RC_SEQ) begin
            for (int k = 0; k <= wt_dly; k++) begin
                if (rst_wait) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    check("rst_pc", pc, RST_PC);
                    check("rst_state", 32'(state_dbg), 32'(mips_pkg::IDLE));
                    check("rst_count", instr_count, 32'd0);
                    check("rst_retire", {31'd0, retire}, 32'd0);
                    rst_n = 1'b1;
                    void'(exp_q.pop_front());
                    model_pc  = RST_PC;
                    model_cnt = 32'd0;
                    return;
                end
                if (drop_run && k == 0) run = 1'b0;
                if (cls == RC_BR) begin
                    bus.cmp_valid = (k == wt_dly);
                    bus.bflag     = (k == wt_dly) ? bf : 1'($urandom);
                    exec_done     = distract;
                end else begin
                    exec_done     = (k == wt_dly);
                    bus.cmp_valid = distract;
                    bus.bflag     = 1'($urandom);
                end
                @(negedge clk);
            end
            bus.cmp_valid = 1'b0;
            exec_done     = 1'b0;
        end

        // UPDATE
        check("retire_update", {31'd0, retire}, 32'd1);
        check("branch_taken", {31'd0, branch_taken}, {31'd0, redir});
        check("link_valid", {31'd0, link_valid}, {31'd0, lnk});
        if (lnk) check("link_pc", link_pc, model_pc + 32'd4);
        check("pc_hold", pc, model_pc);
        @(negedge clk);

        model_pc  = exp_q.pop_front();
        model_cnt = model_cnt + 32'd1;
        check("pc_next", pc, model_pc);
        check("instr_count", instr_count, model_cnt);
        check("retire_once", {31'd0, retire}, 32'd0);
        check("imem_req_after", {31'd0, bus.imem_req}, {31'd0, run});
        if (drop_run) begin
            check("idle_after_stop", 32'(state_dbg), 32'(mips_pkg::IDLE));
            @(negedge clk);
            check("idle_hold", {31'd0, bus.imem_req}, 32'd0);
            run = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] w;
        int kind;

        rst_n          = 1'b0;
        run            = 1'b0;
        exec_done      = 1'b0;
        rs_value       = 32'd0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.bflag      = 1'b0;
        bus.cmp_valid  = 1'b0;
        model_pc       = RST_PC;
        model_cnt      = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("reset_pc", pc, RST_PC);
        check("reset_count", instr_count, 32'd0);
        check("reset_ir", bus.ir, 32'd0);
        check("reset_req", {31'd0, bus.imem_req}, 32'd0);
        check("reset_retire", {31'd0, retire}, 32'd0);
        check("reset_btaken", {31'd0, branch_taken}, 32'd0);
        check("reset_link", {31'd0, link_valid}, 32'd0);
        check("reset_state", 32'(state_dbg), 32'(mips_pkg::IDLE));
        @(negedge clk);
        check("idle_no_run", {31'd0, bus.imem_req}, 32'd0);

        run = 1'b1;
        // SEQ, exec_done one cycle late
        exec_instr(32'h2008_0005, 32'd0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h0109_5020, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h8C08_0010, 32'd0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'hAC08_0010, 32'd0, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0);
        // BEQ to itself, taken then not taken
        exec_instr(32'h1000_FFFF, 32'd0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h1000_FFFF, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h2008_0001, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h2008_0002, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h2008_0003, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        // JAL at 0x3020
        exec_instr(32'h0C00_0C40, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        // JR, misaligned rs, fetch ack delayed two cycles
        exec_instr(32'h03E0_0008, 32'h0000_4007, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
        // run dropped while waiting
        exec_instr(32'h2008_0007, 32'd0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0);
        // reset while waiting
        exec_instr(32'h2008_0009, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        // JR to the top of the address space, then wrap via SEQ with cmp_valid noise
        exec_instr(32'h0120_0008, 32'hFFFF_FFFC, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h2008_000A, 32'd0, 1'b1, 0, 2, 1'b1, 1'b0, 1'b0);
        // BNE with exec_done noise, JALR, REGIMM rt=2 (sequential)
        exec_instr(32'h1509_0010, 32'd0, 1'b1, 0, 1, 1'b1, 1'b0, 1'b0);
        exec_instr(32'h0040_F809, 32'h1234_5679, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h0402_0003, 32'd0, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
        exec_instr(32'h0401_FFF0, 32'd0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        exec_instr(32'h0800_0123, 32'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            w    = $urandom;
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: begin
                    w[31:26] = 6'($urandom_range(4, 7));
                end
                1: begin
                    w[31:26] = 6'd1;
                    w[20:16] = 5'($urandom_range(0, 3));
                end
                2: begin
                    w[31:26] = 6'($urandom_range(2, 3));
                end
                3: begin
                    w[31:26] = 6'd0;
                    w[5:0]   = 6'($urandom_range(7, 10));
                end
                default: begin
                    w[31:26] = 6'($urandom_range(8, 63));
                end
            endcase
            exec_instr(w, $urandom, 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
